cv32e40x_clmul_unit: RTL and testbench



---
 rtl/cv32e40x_clmul_unit.sv | 140 ++++++++++++++
 tb/tb_cv32e40x_clmul_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_clmul_unit.sv
// Multi-cycle Zbc carry-less multiply unit (clmul/clmulh/clmulr).
// Iterates BITS_PER_CYCLE multiplier bits per clock and holds the result until accepted.
module cv32e40x_clmul_unit #(
   parameter int unsigned BITS_PER_CYCLE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   output logic        ready_o,
   input  logic [1:0]  op_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   input  logic        kill_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] result_o
);

   localparam int unsigned NumIter = 32 / BITS_PER_CYCLE;
   localparam int unsigned CntW    = (NumIter > 1) ? $clog2(NumIter) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(NumIter - 1);

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StDone
   } state_e;

   state_e            r_state;
   state_e            w_state_next;
   logic [1:0]        r_op;
   logic [31:0]       r_a;
   logic [31:0]       r_b;
   logic [63:0]       r_acc;
   logic [CntW-1:0]   r_cnt;
   logic [31:0]       r_result;

   logic [63:0]       w_acc_next;
   logic [63:0]       w_a_ext;
   logic [5:0]        w_base;
   logic [31:0]       w_result_sel;
   logic              w_accept;
   logic              w_last;

   assign w_a_ext  = {32'h0, r_a};
   assign w_base   = 6'(r_cnt) * 6'(BITS_PER_CYCLE);
   assign w_last   = (r_cnt == CntLast);
   assign w_accept = (r_state == StIdle) && valid_i && !kill_i;
   assign result_o = r_result;

   // All partial products of this slice of the multiplier are folded in one cycle.
   always_comb begin
      w_acc_next = r_acc;
      for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
         if (r_b[5'(w_base + 6'(j))]) begin
            w_acc_next = w_acc_next ^ (w_a_ext << (w_base + 6'(j)));
         end
      end
   end

   // Reserved encoding 2'b11 falls through to plain clmul.
   always_comb begin
      w_result_sel = w_acc_next[31:0];
      case (r_op)
         2'b01:   w_result_sel = w_acc_next[63:32];
         2'b10:   w_result_sel = w_acc_next[62:31];
         default: w_result_sel = w_acc_next[31:0];
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      ready_o      = 1'b0;
      valid_o      = 1'b0;
      case (r_state)
         StIdle: begin
            ready_o = 1'b1;
            if (valid_i && !kill_i) begin
               w_state_next = StCalc;
            end
         end
         StCalc: begin
            if (kill_i) begin
               w_state_next = StIdle;
            end else if (w_last) begin
               w_state_next = StDone;
            end
         end
         StDone: begin
            valid_o = 1'b1;
            if (kill_i || ready_i) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= StIdle;
         r_op     <= 2'b00;
         r_a      <= 32'h0;
         r_b      <= 32'h0;
         r_acc    <= 64'h0;
         r_cnt    <= '0;
         r_result <= 32'h0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_op  <= op_i;
            r_a   <= op_a_i;
            r_b   <= op_b_i;
            r_acc <= 64'h0;
            r_cnt <= '0;
         end else if (r_state == StCalc) begin
            if (kill_i) begin
               r_acc <= 64'h0;
               r_cnt <= '0;
            end else begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + CntW'(1);
               if (w_last) begin
                  r_result <= w_result_sel;
               end
            end
         end
      end
   end

   a_valid_ready_excl: assert property (@(posedge clk) disable iff (rst)
      !(valid_o && ready_o));

   a_cnt_in_range: assert property (@(posedge clk) disable iff (rst)
      (r_state == StCalc) |-> (int'(r_cnt) < int'(NumIter)));

   a_result_stable: assert property (@(posedge clk) disable iff (rst)
      (valid_o && !ready_i) |=> $stable(result_o));

endmodule

// File: tb/tb_cv32e40x_clmul_unit.sv
// Scoreboard bench for cv32e40x_clmul_unit; five instances cover BITS_PER_CYCLE 4, 1, 2, 8, 32.
module tb_cv32e40x_clmul_unit;

   localparam int NumInst = 5;

   function automatic int unsigned bpc_of(input int idx);
      case (idx)
         0:       return 4;
         1:       return 1;
         2:       return 2;
         3:       return 8;
         default: return 32;
      endcase
   endfunction

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NumInst-1:0] valid_v;
   logic [NumInst-1:0] ready_v;
   logic [NumInst-1:0] vout_v;
   logic [1:0]         op;
   logic [31:0]        op_a;
   logic [31:0]        op_b;
   logic               kill;
   logic               ready_i;
   logic [31:0]        res_v [NumInst];

   logic [31:0]        exp_q [NumInst][$];
   int                 n_cmp = 0;
   int                 n_fail = 0;
   int                 cyc = 0;
   int                 acc_cyc [NumInst];
   logic [NumInst-1:0] pend;
   logic [NumInst-1:0] prev_v;
   logic [31:0]        mon_exp;
   int                 mon_lat;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < NumInst; gi++) begin : g_inst
      cv32e40x_clmul_unit #(
         .BITS_PER_CYCLE(bpc_of(gi))
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .valid_i  (valid_v[gi]),
         .ready_o  (ready_v[gi]),
         .op_i     (op),
         .op_a_i   (op_a),
         .op_b_i   (op_b),
         .kill_i   (kill),
         .valid_o  (vout_v[gi]),
         .ready_i  (ready_i),
         .result_o (res_v[gi])
      );
   end

   // Monitor: latency on valid_o rise, result on each non-killed handshake.
   always @(negedge clk) begin
      for (int i = 0; i < NumInst; i++) begin
         if (rst) begin
            pend[i]   = 1'b0;
            prev_v[i] = 1'b0;
         end else begin
            n_cmp++;
            if (vout_v[i] && ready_v[i]) begin
               n_fail++;
               $display("FAIL inst%0d valid_ready_excl: valid_o=1 ready_o=1, required not both", i);
            end
            if (vout_v[i] && !prev_v[i] && pend[i]) begin
               pend[i] = 1'b0;
               mon_lat = cyc - acc_cyc[i];
               n_cmp++;
               if (mon_lat != int'(32 / bpc_of(i)) + 1) begin
                  n_fail++;
                  $display("FAIL inst%0d latency: got %0d cycles, required %0d", i, mon_lat,
                           int'(32 / bpc_of(i)) + 1);
               end
            end
            if (vout_v[i] && ready_i && !kill) begin
               n_cmp++;
               if (exp_q[i].size() == 0) begin
                  n_fail++;
                  $display("FAIL inst%0d unexpected_result: got %h, required no result", i, res_v[i]);
               end else begin
                  mon_exp = exp_q[i].pop_front();
                  if (res_v[i] !== mon_exp) begin
                     n_fail++;
                     $display("FAIL inst%0d result: got %h, required %h", i, res_v[i], mon_exp);
                  end
               end
            end
            if (valid_v[i] && ready_v[i] && !kill) begin
               acc_cyc[i] = cyc;
               pend[i]    = 1'b1;
            end
            prev_v[i] = vout_v[i];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic issue(input logic [NumInst-1:0] mask, input logic [1:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e, input bit push);
      int t = 0;
      while ((ready_v & mask) != mask && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("issue_ready", 32'(ready_v & mask), 32'(mask));
      op      = o;
      op_a    = x;
      op_b    = y;
      valid_v = mask;
      if (push) begin
         for (int i = 0; i < NumInst; i++) begin
            if (mask[i]) exp_q[i].push_back(e);
         end
      end
      @(posedge clk);
      #1;
      // Scramble inputs: the unit must have latched its operands.
      valid_v = '0;
      op      = ~o;
      op_a    = ~x;
      op_b    = 32'hDEADBEEF;
   endtask

   task automatic wait_done(input logic [NumInst-1:0] mask);
      int t = 0;
      do begin
         @(posedge clk);
         #1;
         t++;
      end while ((ready_v & mask) != mask && t < 200);
      check("done_ready", 32'(ready_v & mask), 32'(mask));
   endtask

   task automatic wait_valid();
      int t = 0;
      while (!vout_v[0] && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("wait_valid", 32'(vout_v[0]), 32'h1);
   endtask

   initial begin
      logic seen;
      valid_v = '0;
      op      = 2'b00;
      op_a    = 32'h0;
      op_b    = 32'h0;
      kill    = 1'b0;
      ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready_v), 32'h1f);
      check("rst_valid", 32'(vout_v), 32'h0);
      check("rst_result", res_v[0], 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic clmul, then ready_o must return the cycle after the handshake.
      issue(5'h01, 2'b00, 32'h3, 32'h3, 32'h5, 1'b1);
      wait_valid();
      @(posedge clk);
      #1;
      check("t1_ready_after", 32'(ready_v[0]), 32'h1);
      check("t1_valid_after", 32'(vout_v[0]), 32'h0);

      issue(5'h01, 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1);
      wait_done(5'h01);
      issue(5'h01, 2'b10, 32'h80000000, 32'h80000000, 32'h80000000, 1'b1);
      wait_done(5'h01);

      // All configurations in lockstep.
      issue(5'h1f, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 1'b1);
      wait_done(5'h1f);
      issue(5'h1f, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 1'b1);
      wait_done(5'h1f);
      issue(5'h1f, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAAAAAA, 1'b1);
      wait_done(5'h1f);
      issue(5'h1f, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 1'b1);
      wait_done(5'h1f);
      issue(5'h1f, 2'b00, 32'hF0F0F0F0, 32'h00000101, 32'h000000F0, 1'b1);
      wait_done(5'h1f);
      issue(5'h1f, 2'b10, 32'hF0F0F0F0, 32'h00000101, 32'h000001E0, 1'b1);
      wait_done(5'h1f);

      // Result stall with a competing request.
      ready_i = 1'b0;
      issue(5'h01, 2'b00, 32'h3, 32'h3, 32'h5, 1'b1);
      wait_valid();
      for (int c = 0; c < 5; c++) begin
         valid_v[0] = 1'b1;
         op_a       = 32'hFF;
         op_b       = 32'hFF;
         @(posedge clk);
         #1;
         check("stall_valid", 32'(vout_v[0]), 32'h1);
         check("stall_result", res_v[0], 32'h5);
         check("stall_ready", 32'(ready_v[0]), 32'h0);
      end
      valid_v[0] = 1'b0;
      ready_i    = 1'b1;
      @(posedge clk);
      #1;
      check("stall_release_ready", 32'(ready_v[0]), 32'h1);
      check("stall_release_valid", 32'(vout_v[0]), 32'h0);

      // Kill in CALC at cnt==3.
      issue(5'h01, 2'b00, 32'h12345678, 32'h0000FFFF, 32'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      check("kill_calc_valid", 32'(vout_v[0]), 32'h0);
      check("kill_calc_ready", 32'(ready_v[0]), 32'h1);
      issue(5'h01, 2'b00, 32'h5, 32'h1, 32'h5, 1'b1);
      wait_done(5'h01);

      // Kill coincident with the DONE handshake: handshake is void.
      issue(5'h01, 2'b00, 32'h7, 32'h3, 32'h0, 1'b0);
      wait_valid();
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      check("kill_done_valid", 32'(vout_v[0]), 32'h0);
      check("kill_done_ready", 32'(ready_v[0]), 32'h1);
      check("kill_done_result", res_v[0], 32'h9);

      // Kill coincident with a request in IDLE: not accepted.
      valid_v[0] = 1'b1;
      op         = 2'b00;
      op_a       = 32'h3;
      op_b       = 32'h3;
      kill       = 1'b1;
      @(posedge clk);
      #1;
      valid_v[0] = 1'b0;
      kill       = 1'b0;
      check("kill_idle_ready", 32'(ready_v[0]), 32'h1);
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         seen = seen | vout_v[0];
      end
      check("kill_idle_no_valid", 32'(seen), 32'h0);

      // Asynchronous reset between clock edges during CALC.
      issue(5'h01, 2'b00, 32'h3, 32'h3, 32'h0, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(vout_v[0]), 32'h0);
      check("arst_ready", 32'(ready_v[0]), 32'h1);
      check("arst_result", res_v[0], 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      issue(5'h01, 2'b01, 32'hF0F0F0F0, 32'h00000101, 32'h000000F0, 1'b1);
      wait_done(5'h01);

      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NumInst; i++) begin
         check($sformatf("queue_empty_inst%0d", i), 32'(exp_q[i].size()), 32'h0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
